// File: rtl/and_cov_checker.sv
// Coverage and correctness checker for a 2-input AND gate stage: bins {a,b} hits, flags y != a&b.
// Optional build macro AND_COV_STOP_ON_ERR_EN: first mismatch freezes the checker in HALT.

module and_cov_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && cnt != '1)
         cnt <= cnt + W'(1);
   end
endmodule

module and_cov_checker #(
   parameter int CNT_W = 8,
   parameter int GOAL  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   input  logic             clr,
   input  logic [1:0]       rd_sel,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [3:0]       bins_hit,
   output logic             cov_done,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, CLOSED = 2'd2, HALT = 2'd3} state_t;

   localparam logic [CNT_W:0] GOAL_V = (CNT_W+1)'(GOAL);

   state_t                  st;
   logic                    accept;
   logic                    err_inc;
   logic [3:0]              inc;
   logic [3:0]              nxt_hit;
   logic [3:0][CNT_W-1:0]   bin_cnt;

   assign accept  = in_valid && !clr && (st != HALT);
   assign err_inc = accept && (y != (a & b));

   // A mismatching sample still lands in its bin: coverage tracks stimulus only.
   for (genvar i = 0; i < 4; i++) begin : g_bin
      assign inc[i] = accept && ({a, b} == 2'(i));
      and_cov_sat_cnt #(.W(CNT_W)) u_bin (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .inc (inc[i]),
         .cnt (bin_cnt[i])
      );
      assign bins_hit[i] = {1'b0, bin_cnt[i]} >= GOAL_V;
      assign nxt_hit[i]  = ({1'b0, bin_cnt[i]} + (CNT_W+1)'(inc[i])) >= GOAL_V;
   end

   and_cov_sat_cnt #(.W(CNT_W)) u_smp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (accept),
      .cnt (sample_cnt)
   );

   and_cov_sat_cnt #(.W(CNT_W)) u_err (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (err_inc),
      .cnt (err_cnt)
   );

   assign cov_done = &bins_hit;
   assign rd_cnt   = bin_cnt[rd_sel];
   assign state    = st;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         st        <= IDLE;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= err_inc;
         case (st)
            IDLE: begin
`ifdef AND_COV_STOP_ON_ERR_EN
               if (err_inc)     st <= HALT;
               else if (accept) st <= COLLECT;
`else
               if (accept)      st <= COLLECT;
`endif
            end
            COLLECT: begin
`ifdef AND_COV_STOP_ON_ERR_EN
               if (err_inc)                  st <= HALT;
               else if (accept && &nxt_hit)  st <= CLOSED;
`else
               if (accept && &nxt_hit)       st <= CLOSED;
`endif
            end
            CLOSED: begin
`ifdef AND_COV_STOP_ON_ERR_EN
               if (err_inc) st <= HALT;
`endif
            end
            default: st <= st;
         endcase
      end
   end
endmodule

// File: tb/tb_and_cov_checker.sv
// Scoreboard bench for and_cov_checker: three instances (default, CNT_W=3, GOAL=2) driven by directed vectors.

module tb_and_cov_checker;
   localparam int F_RD = 0, F_BH = 1, F_CD = 2, F_EP = 3, F_EC = 4, F_SC = 5, F_ST = 6;

   typedef struct {
      int    due;
      int    dut;
      int    fld;
      int    val;
      string nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic iv[3], ia[3], ib[3], iy[3], ic[3];
   logic [1:0] rs[3];

   logic [7:0] rd_cnt0, rd_cnt2, err_cnt0, err_cnt2, sample_cnt0, sample_cnt2;
   logic [2:0] rd_cnt1, err_cnt1, sample_cnt1;
   logic [3:0] bh[3];
   logic       cd[3], ep[3];
   logic [1:0] st[3];

   int   cyc = 0;
   int   errs = 0;
   int   checks = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   and_cov_checker #(.CNT_W(8), .GOAL(1)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .a(ia[0]), .b(ib[0]), .y(iy[0]), .clr(ic[0]),
      .rd_sel(rs[0]), .rd_cnt(rd_cnt0), .bins_hit(bh[0]), .cov_done(cd[0]), .err_pulse(ep[0]),
      .err_cnt(err_cnt0), .sample_cnt(sample_cnt0), .state(st[0]));

   and_cov_checker #(.CNT_W(3), .GOAL(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .a(ia[1]), .b(ib[1]), .y(iy[1]), .clr(ic[1]),
      .rd_sel(rs[1]), .rd_cnt(rd_cnt1), .bins_hit(bh[1]), .cov_done(cd[1]), .err_pulse(ep[1]),
      .err_cnt(err_cnt1), .sample_cnt(sample_cnt1), .state(st[1]));

   and_cov_checker #(.CNT_W(8), .GOAL(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .a(ia[2]), .b(ib[2]), .y(iy[2]), .clr(ic[2]),
      .rd_sel(rs[2]), .rd_cnt(rd_cnt2), .bins_hit(bh[2]), .cov_done(cd[2]), .err_pulse(ep[2]),
      .err_cnt(err_cnt2), .sample_cnt(sample_cnt2), .state(st[2]));

   function automatic int get(int d, int f);
      case (f)
         F_RD:    return d == 0 ? int'(rd_cnt0) : d == 1 ? int'(rd_cnt1) : int'(rd_cnt2);
         F_BH:    return int'(bh[d]);
         F_CD:    return int'(cd[d]);
         F_EP:    return int'(ep[d]);
         F_EC:    return d == 0 ? int'(err_cnt0) : d == 1 ? int'(err_cnt1) : int'(err_cnt2);
         F_SC:    return d == 0 ? int'(sample_cnt0) : d == 1 ? int'(sample_cnt1) : int'(sample_cnt2);
         default: return int'(st[d]);
      endcase
   endfunction

   // Monitor: retire every expectation that falls due on this cycle.
   always @(negedge clk) begin
      int act;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].due == cyc) begin
            act = get(q[i].dut, q[i].fld);
            checks++;
            if (act != q[i].val) begin
               errs++;
               $display("FAIL %s dut%0d cyc%0d: got %0d expected %0d", q[i].nm, q[i].dut, cyc, act, q[i].val);
            end
            q.delete(i);
         end
      end
   end

   task automatic ex(int d, string nm, int f, int v, int dly);
      exp_t e;
      e.due = cyc + dly; e.dut = d; e.fld = f; e.val = v; e.nm = nm;
      q.push_back(e);
   endtask

   // Advance one cycle; valid/clr default low so each sample is a single-cycle strobe.
   task automatic step();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0;
         ic[d] = 1'b0;
      end
   endtask

   task automatic smp(int d, logic a_, logic b_, logic y_, logic c_ = 1'b0);
      iv[d] = 1'b1; ia[d] = a_; ib[d] = b_; iy[d] = y_; ic[d] = c_;
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ia[d] = 1'b0; ib[d] = 1'b0; iy[d] = 1'b0; ic[d] = 1'b0; rs[d] = 2'd0;
      end

      // Reset then idle
      step();
      step();
      ex(0, "rst_state", F_ST, 0, 0);
      ex(0, "rst_smp", F_SC, 0, 0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         ex(0, "idle_state", F_ST, 0, 0);
         ex(0, "idle_smp", F_SC, 0, 0);
         ex(0, "idle_bins", F_BH, 0, 0);
         ex(0, "idle_err", F_EC, 0, 0);
         ex(0, "idle_ep", F_EP, 0, 0);
         ex(0, "idle_rd", F_RD, 0, 0);
         ex(1, "idle_state", F_ST, 0, 0);
         ex(2, "idle_cov", F_CD, 0, 0);
      end

      // Full coverage with a correct gate, back-to-back samples
      step(); smp(0, 0, 0, 0); ex(0, "cov_s1_state", F_ST, 1, 1);
      step(); smp(0, 0, 1, 0); ex(0, "cov_s2_bins", F_BH, 4'b0011, 1);
      step(); smp(0, 1, 0, 0); ex(0, "cov_s3_cd", F_CD, 0, 1); ex(0, "cov_s3_state", F_ST, 1, 1);
      step(); smp(0, 1, 1, 1); rs[0] = 2'd3;
      ex(0, "cov_bins", F_BH, 4'b1111, 1);
      ex(0, "cov_done", F_CD, 1, 1);
      ex(0, "cov_state", F_ST, 2, 1);
      ex(0, "cov_smp", F_SC, 4, 1);
      ex(0, "cov_err", F_EC, 0, 1);
      ex(0, "cov_rd3", F_RD, 1, 1);
      ex(0, "cov_ep", F_EP, 0, 1);
      step();

      // clr colliding with a sample: sample dropped, everything back to zero
      smp(0, 1, 1, 1, 1'b1);
      ex(0, "clr_smp", F_SC, 0, 1);
      ex(0, "clr_cd", F_CD, 0, 1);
      ex(0, "clr_state", F_ST, 0, 1);
      ex(0, "clr_bins", F_BH, 0, 1);
      ex(0, "clr_rd3", F_RD, 0, 1);
      step();
      step();

      // Mismatch detection from a clean state
      smp(0, 1, 1, 0);
      ex(0, "mm_ep", F_EP, 1, 1);
      ex(0, "mm_err", F_EC, 1, 1);
      ex(0, "mm_rd3", F_RD, 1, 1);
`ifdef AND_COV_STOP_ON_ERR_EN
      ex(0, "mm_state", F_ST, 3, 1);
`else
      ex(0, "mm_state", F_ST, 1, 1);
`endif
      step();
      smp(0, 0, 0, 0);
      ex(0, "mm_ep_off", F_EP, 0, 1);
      ex(0, "mm_err_hold", F_EC, 1, 1);
`ifdef AND_COV_STOP_ON_ERR_EN
      ex(0, "mm_smp", F_SC, 1, 1);
      ex(0, "mm_halt", F_ST, 3, 1);
`else
      ex(0, "mm_smp", F_SC, 2, 1);
      ex(0, "mm_collect", F_ST, 1, 1);
`endif
      step();
      ic[0] = 1'b1;
      ex(0, "mm_clr_state", F_ST, 0, 1);
      ex(0, "mm_clr_err", F_EC, 0, 1);
      step();

      // Saturation at CNT_W=3
      rs[1] = 2'd0;
      for (int k = 1; k <= 10; k++) begin
         smp(1, 0, 0, 0);
         ex(1, "sat_smp", F_SC, (k > 7) ? 7 : k, 1);
         ex(1, "sat_rd0", F_RD, (k > 7) ? 7 : k, 1);
         step();
      end
      ex(1, "sat_state", F_ST, 1, 0);
      ex(1, "sat_cd", F_CD, 0, 0);

      // GOAL=2: one pass is not enough, the second pass closes on the 8th sample
      for (int p = 0; p < 2; p++) begin
         smp(2, 0, 0, 0); step();
         smp(2, 0, 1, 0); step();
         smp(2, 1, 0, 0);
         if (p == 1) begin
            ex(2, "g2_s7_cd", F_CD, 0, 1);
            ex(2, "g2_s7_bins", F_BH, 4'b0111, 1);
         end
         step();
         smp(2, 1, 1, 1);
         ex(2, "g2_cd", F_CD, p, 1);
         ex(2, "g2_state", F_ST, p == 1 ? 2 : 1, 1);
         ex(2, "g2_bins", F_BH, p == 1 ? 4'b1111 : 4'b0000, 1);
         step();
      end
      ex(2, "g2_smp", F_SC, 8, 0);

      step();
      step();
      if (q.size() != 0) begin
         errs += q.size();
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
